nbit_bitmap_encoder: RTL and testbench

//  Inverse of the N-bit one-hot decoder (idx -> 1<<idx). Accepts a 2**N-bit bitmap and emits the
//  N-bit index of every set bit, one index per handshake beat, in priority order.

---
 rtl/nbit_bitmap_encoder.sv | 102 ++++++++++
 tb/tb_nbit_bitmap_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nbit_bitmap_encoder.sv
// nbit_bitmap_encoder: serialises a 2**N-bit bitmap into the N-bit indices of its
// set bits, one index per valid/ready beat, lowest-first or highest-first.
module nbit_bitmap_encoder #(
  parameter int unsigned N         = 3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_idx,
  output logic              out_last,
  output logic [N:0]        out_count
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned CW = N + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pending_q, pending_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           last_q, last_d;

  // Index of the next bit to emit; the later match in the scan wins.
  function automatic logic [N-1:0] pick_idx(input logic [W-1:0] v);
    logic [N-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(W); i++) if (v[i]) idx = N'(i);
    end else begin
      for (int i = int'(W) - 1; i >= 0; i--) if (v[i]) idx = N'(i);
    end
    return idx;
  endfunction

  // Number of set bits, 0..2**N.
  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(W); i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Next-state logic; idx/last are precomputed from the next pending value so the
  // outputs come straight from flops with no path from in_* to out_*.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          count_d   = popcount(in_vec);
          if (in_vec != '0) state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(W'(1) << idx_q);
          if (last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    idx_d  = pick_idx(pending_d);
    last_d = (pending_d != '0) && ((pending_d & (pending_d - W'(1))) == '0);
  end

  // State and burst registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_nbit_bitmap_encoder.sv
// Bench for nbit_bitmap_encoder: an LSB-first and an MSB-first instance driven with
// directed and random bitmaps, checked beat by beat against an index-queue model.
module tb_nbit_bitmap_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_vec    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [2:0] out_idx   [2];
  logic       out_last  [2];
  logic [3:0] out_count [2];

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  nbit_bitmap_encoder #(.N(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(in_vec[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_idx(out_idx[0]),
    .out_last(out_last[0]), .out_count(out_count[0])
  );

  nbit_bitmap_encoder #(.N(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(in_vec[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_idx(out_idx[1]),
    .out_last(out_last[1]), .out_count(out_count[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected emission order: set bit positions ascending (d=0) or descending (d=1).
  function automatic void build_exp(input int d, input logic [7:0] v);
    exp_q.delete();
    if (d == 0) begin
      for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) exp_q.push_back(i);
    end
  endfunction

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles on the idx=2 beat.
  task automatic send(input int d, input logic [7:0] v, input int mode);
    int         exp_cnt;
    int         stall;
    int         budget;
    int         beats;
    logic [7:0] recon;
    logic [2:0] obs;
    logic       rdy;
    chk("idle_in_ready", int'(in_ready[d]), 1);
    build_exp(d, v);
    exp_cnt = exp_q.size();
    recon = '0;
    beats = 0;
    stall = 0;
    budget = 0;
    in_valid[d]  = 1'b1;
    in_vec[d]    = v;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_vec[d]   = 8'($urandom);
    if (exp_cnt == 0) begin
      chk("zero_out_valid", int'(out_valid[d]), 0);
      chk("zero_in_ready", int'(in_ready[d]), 1);
      chk("zero_count", int'(out_count[d]), 0);
      return;
    end
    while (exp_q.size() > 0 && budget < 200) begin
      chk("scan_valid", int'(out_valid[d]), 1);
      chk("scan_in_ready", int'(in_ready[d]), 0);
      chk("scan_idx", int'(out_idx[d]), exp_q[0]);
      chk("scan_last", int'(out_last[d]), int'(exp_q.size() == 1));
      chk("scan_count", int'(out_count[d]), exp_cnt);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (exp_q[0] == 2 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      obs = out_idx[d];
      out_ready[d] = rdy;
      in_valid[d]  = 1'($urandom);
      in_vec[d]    = 8'($urandom);
      @(posedge clk); #1;
      budget++;
      if (rdy && out_valid[d] === 1'b0) begin
        // valid already sampled high above; nothing extra to do here
      end
      if (rdy) begin
        recon = recon | (8'(1) << obs);
        beats++;
        void'(exp_q.pop_front());
      end
    end
    in_valid[d] = 1'b0;
    chk("burst_in_budget", int'(budget < 200), 1);
    chk("post_out_valid", int'(out_valid[d]), 0);
    chk("post_in_ready", int'(in_ready[d]), 1);
    chk("roundtrip_or", int'(recon), int'(v));
    chk("beats_eq_popcount", beats, $countones(v));
  endtask

  // Reset in the middle of an 8'hFF burst, then a fresh single-bit burst.
  task automatic reset_mid();
    chk("rm_idle", int'(in_ready[0]), 1);
    in_valid[0]  = 1'b1;
    in_vec[0]    = 8'hFF;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rm_valid", int'(out_valid[0]), 1);
      chk("rm_idx", int'(out_idx[0]), i);
      chk("rm_count", int'(out_count[0]), 8);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    chk("rm_rst_out_valid", int'(out_valid[0]), 0);
    chk("rm_rst_in_ready", int'(in_ready[0]), 1);
    chk("rm_rst_idx", int'(out_idx[0]), 0);
    chk("rm_rst_count", int'(out_count[0]), 0);
    @(posedge clk); #1;
    chk("rm_rst_hold_valid", int'(out_valid[0]), 0);
    rst = 1'b0;
    send(0, 8'b0000_1000, 0);
  endtask

  initial begin
    logic [7:0] v;
    int         d;
    int         sel;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_vec[i]    = '0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", int'(in_ready[i]), 1);
      chk("rst_out_valid", int'(out_valid[i]), 0);
      chk("rst_out_idx", int'(out_idx[i]), 0);
      chk("rst_out_last", int'(out_last[i]), 0);
      chk("rst_out_count", int'(out_count[i]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    send(0, 8'b0001_0000, 0);
    send(0, 8'b1010_0110, 0);
    send(0, 8'b1010_0110, 2);
    send(0, 8'h00, 0);
    send(1, 8'hFF, 0);
    send(1, 8'b1010_0110, 2);
    reset_mid();

    for (int n = 0; n < 80; n++) begin
      d   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      v = 8'h00;
      else if (sel == 1) v = 8'hFF;
      else               v = 8'($urandom);
      send(d, v, (sel < 7) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
